inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 148 ++++++++++++++
 tb/tb_inst_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot loader: receives a length-prefixed program over a byte stream, writes it
// word by word into instruction memory and releases the processor on a good checksum.
module inst_loader #(
  parameter int MAX_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [31:0] inst_out,
  output logic [11:0] inst_addr_out,
  output logic        inst_we_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out,
  output logic        proc_rst_out
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_N    = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t        r_state;
  logic [7:0]    r_len_lo;
  logic [15:0]   r_len;
  logic [15:0]   r_word_idx;
  logic [1:0]    r_lane;
  logic [23:0]   r_buf;
  logic [7:0]    r_chk;
  logic [TW-1:0] r_to_cnt;
  logic [31:0]   r_inst;
  logic [11:0]   r_addr;
  logic          r_we;

  logic [15:0]   w_len;
  logic          w_len_ok;
  logic          w_last_word;
  logic          w_timeout;

  assign w_len       = {byte_in, r_len_lo};
  assign w_len_ok    = (w_len != 16'd0) && ({1'b0, w_len} <= MAX_N);
  assign w_last_word = (r_word_idx == (r_len - 16'd1));
  assign w_timeout   = (r_to_cnt == TO_LIMIT);

  // Loader FSM with byte assembly, checksum, timeout and write strobe generation.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_len_lo   <= 8'd0;
      r_len      <= 16'd0;
      r_word_idx <= 16'd0;
      r_lane     <= 2'd0;
      r_buf      <= 24'd0;
      r_chk      <= 8'd0;
      r_to_cnt   <= '0;
      r_inst     <= 32'd0;
      r_addr     <= 12'd0;
      r_we       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (byte_valid_in) begin
            r_len_lo <= byte_in;
            r_to_cnt <= '0;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (byte_valid_in) begin
            r_to_cnt <= '0;
            if (w_len_ok) begin
              r_len      <= w_len;
              r_word_idx <= 16'd0;
              r_lane     <= 2'd0;
              r_chk      <= 8'd0;
              r_state    <= S_DATA;
            end else begin
              r_state <= S_ERROR;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (byte_valid_in) begin
            r_to_cnt <= '0;
            r_chk    <= r_chk ^ byte_in;
            r_lane   <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_buf[7:0]   <= byte_in;
              2'd1: r_buf[15:8]  <= byte_in;
              2'd2: r_buf[23:16] <= byte_in;
              default: begin
                // Fourth byte completes the word; strobe it out next cycle.
                r_inst     <= {byte_in, r_buf};
                r_addr     <= r_word_idx[11:0];
                r_we       <= 1'b1;
                r_word_idx <= r_word_idx + 16'd1;
                if (w_last_word) begin
                  r_state <= S_CHECK;
                end
              end
            endcase
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          if (byte_valid_in) begin
            r_to_cnt <= '0;
            r_state  <= (byte_in == r_chk) ? S_DONE : S_ERROR;
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_out      = r_inst;
  assign inst_addr_out = r_addr;
  assign inst_we_out   = r_we;
  assign busy_out      = (r_state == S_LEN_HI) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign done_out      = (r_state == S_DONE);
  assign error_out     = (r_state == S_ERROR);
  assign proc_rst_out  = (r_state != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frame loading, checksum, length limits,
// timeout boundary, mid-load reset and behaviour after completion.
module tb_inst_loader;

  logic        clk_100mhz = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid_in = 1'b0;
  logic [31:0] inst_out;
  logic [11:0] inst_addr_out;
  logic        inst_we_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;
  logic        proc_rst_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] wq_data[$];
  logic [11:0] wq_addr[$];

  inst_loader #(.MAX_WORDS(4096), .TIMEOUT_CYCLES(16)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_in       (rst_in),
    .byte_in      (byte_in),
    .byte_valid_in(byte_valid_in),
    .inst_out     (inst_out),
    .inst_addr_out(inst_addr_out),
    .inst_we_out  (inst_we_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .error_out    (error_out),
    .proc_rst_out (proc_rst_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Record every write strobe just after the edge that produced it.
  always @(posedge clk_100mhz) begin
    #1;
    if (inst_we_out === 1'b1) begin
      wq_data.push_back(inst_out);
      wq_addr.push_back(inst_addr_out);
    end
  end

  task automatic send(input logic [7:0] b);
    byte_in       = b;
    byte_valid_in = 1'b1;
    @(negedge clk_100mhz);
    byte_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid_in = 1'b0;
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    byte_valid_in = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    rst_in = 1'b0;
    wq_data.delete();
    wq_addr.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (inst_out !== 32'd0) $display("FAIL rst_inst: got %h want 0", inst_out); else n_pass++;
    n_total++; if (inst_addr_out !== 12'd0) $display("FAIL rst_addr: got %h want 0", inst_addr_out); else n_pass++;
    n_total++; if (inst_we_out !== 1'b0) $display("FAIL rst_we: got %b want 0", inst_we_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else n_pass++;
    n_total++; if (done_out !== 1'b0) $display("FAIL rst_done: got %b want 0", done_out); else n_pass++;
    n_total++; if (error_out !== 1'b0) $display("FAIL rst_error: got %b want 0", error_out); else n_pass++;
    n_total++; if (proc_rst_out !== 1'b1) $display("FAIL rst_proc_rst: got %b want 1", proc_rst_out); else n_pass++;
  endtask

  task automatic test_good_frame();
    do_reset();
    send(8'h02); send(8'h00);
    n_total++; if (busy_out !== 1'b1) $display("FAIL good_busy_len: got %b want 1", busy_out); else n_pass++;
    send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    n_total++; if (inst_we_out !== 1'b1) $display("FAIL good_we0: got %b want 1", inst_we_out); else n_pass++;
    n_total++; if (inst_out !== 32'h00100513) $display("FAIL good_word0: got %h want 00100513", inst_out); else n_pass++;
    n_total++; if (inst_addr_out !== 12'd0) $display("FAIL good_addr0: got %h want 0", inst_addr_out); else n_pass++;
    send(8'h93);
    n_total++; if (inst_we_out !== 1'b0) $display("FAIL good_we_drop: got %b want 0", inst_we_out); else n_pass++;
    send(8'h05); send(8'h15); send(8'h00);
    n_total++; if (inst_we_out !== 1'b1) $display("FAIL good_we1: got %b want 1", inst_we_out); else n_pass++;
    n_total++; if (inst_out !== 32'h00150593) $display("FAIL good_word1: got %h want 00150593", inst_out); else n_pass++;
    n_total++; if (inst_addr_out !== 12'd1) $display("FAIL good_addr1: got %h want 1", inst_addr_out); else n_pass++;
    n_total++; if (busy_out !== 1'b1) $display("FAIL good_busy_check: got %b want 1", busy_out); else n_pass++;
    // XOR of the eight data bytes is 0x85.
    send(8'h85);
    n_total++; if (done_out !== 1'b1) $display("FAIL good_done: got %b want 1", done_out); else n_pass++;
    n_total++; if (proc_rst_out !== 1'b0) $display("FAIL good_proc_rst: got %b want 0", proc_rst_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL good_busy_end: got %b want 0", busy_out); else n_pass++;
    n_total++; if (wq_addr.size() !== 2) $display("FAIL good_nwrites: got %0d want 2", wq_addr.size()); else n_pass++;
  endtask

  task automatic test_after_done();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    idle(3);
    n_total++; if (wq_addr.size() !== 2) $display("FAIL post_nwrites: got %0d want 2", wq_addr.size()); else n_pass++;
    n_total++; if (done_out !== 1'b1) $display("FAIL post_done: got %b want 1", done_out); else n_pass++;
    n_total++; if (proc_rst_out !== 1'b0) $display("FAIL post_proc_rst: got %b want 0", proc_rst_out); else n_pass++;
    n_total++; if (error_out !== 1'b0) $display("FAIL post_error: got %b want 0", error_out); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h00);
    idle(3);
    n_total++; if (error_out !== 1'b1) $display("FAIL chk_error: got %b want 1", error_out); else n_pass++;
    n_total++; if (done_out !== 1'b0) $display("FAIL chk_done: got %b want 0", done_out); else n_pass++;
    n_total++; if (proc_rst_out !== 1'b1) $display("FAIL chk_proc_rst: got %b want 1", proc_rst_out); else n_pass++;
    n_total++; if (wq_addr.size() !== 1) $display("FAIL chk_nwrites: got %0d want 1", wq_addr.size()); else n_pass++;
    n_total++; if (wq_data[0] !== 32'hDEADBEEF) $display("FAIL chk_word: got %h want deadbeef", wq_data[0]); else n_pass++;
    n_total++; if (wq_addr[0] !== 12'd0) $display("FAIL chk_addr: got %h want 0", wq_addr[0]); else n_pass++;
  endtask

  task automatic test_bad_length();
    do_reset();
    send(8'h00);
    n_total++; if (busy_out !== 1'b1) $display("FAIL len_busy_lo: got %b want 1", busy_out); else n_pass++;
    send(8'h00);
    n_total++; if (error_out !== 1'b1) $display("FAIL len_zero_error: got %b want 1", error_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL len_zero_busy: got %b want 0", busy_out); else n_pass++;
    do_reset();
    send(8'h01); send(8'h10);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    n_total++; if (error_out !== 1'b1) $display("FAIL len_big_error: got %b want 1", error_out); else n_pass++;
    n_total++; if (wq_addr.size() !== 0) $display("FAIL len_big_nwrites: got %0d want 0", wq_addr.size()); else n_pass++;
    do_reset();
    send(8'h00); send(8'h10);
    n_total++; if (busy_out !== 1'b1) $display("FAIL len_max_busy: got %b want 1", busy_out); else n_pass++;
    n_total++; if (error_out !== 1'b0) $display("FAIL len_max_error: got %b want 0", error_out); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h01); idle(15); send(8'h00);
    send(8'hEF); idle(15); send(8'hBE);
    send(8'hAD); send(8'hDE); idle(15);
    n_total++; if (busy_out !== 1'b1) $display("FAIL to15_busy: got %b want 1", busy_out); else n_pass++;
    send(8'h22);
    n_total++; if (done_out !== 1'b1) $display("FAIL to15_done: got %b want 1", done_out); else n_pass++;
    n_total++; if (wq_data[0] !== 32'hDEADBEEF) $display("FAIL to15_word: got %h want deadbeef", wq_data[0]); else n_pass++;
    do_reset();
    send(8'h01); send(8'h00); send(8'hEF);
    idle(15);
    n_total++; if (error_out !== 1'b0) $display("FAIL to16_early: got %b want 0", error_out); else n_pass++;
    idle(1);
    n_total++; if (error_out !== 1'b1) $display("FAIL to16_error: got %b want 1", error_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL to16_busy: got %b want 0", busy_out); else n_pass++;
    n_total++; if (wq_addr.size() !== 0) $display("FAIL to16_nwrites: got %0d want 0", wq_addr.size()); else n_pass++;
  endtask

  task automatic test_reset_midload();
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h10); send(8'h00); send(8'h93); send(8'h05);
    n_total++; if (wq_addr.size() !== 1) $display("FAIL mid_pre_nwrites: got %0d want 1", wq_addr.size()); else n_pass++;
    do_reset();
    idle(2);
    n_total++; if (wq_addr.size() !== 0) $display("FAIL mid_rst_nwrites: got %0d want 0", wq_addr.size()); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy_out); else n_pass++;
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'h08);
    n_total++; if (wq_addr.size() !== 1) $display("FAIL mid_nwrites: got %0d want 1", wq_addr.size()); else n_pass++;
    n_total++; if (wq_data[0] !== 32'h12345678) $display("FAIL mid_word: got %h want 12345678", wq_data[0]); else n_pass++;
    n_total++; if (wq_addr[0] !== 12'd0) $display("FAIL mid_addr: got %h want 0", wq_addr[0]); else n_pass++;
    n_total++; if (done_out !== 1'b1) $display("FAIL mid_done: got %b want 1", done_out); else n_pass++;
  endtask

  initial begin
    @(negedge clk_100mhz);
    test_reset();
    test_good_frame();
    n_total++; if (wq_data[0] !== 32'h00100513) $display("FAIL good_q0: got %h want 00100513", wq_data[0]); else n_pass++;
    n_total++; if (wq_data[1] !== 32'h00150593 || wq_addr[1] !== 12'd1) $display("FAIL good_q1: got %h@%h want 00150593@001", wq_data[1], wq_addr[1]); else n_pass++;
    test_after_done();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
